// File: rtl/qblock_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : qblock_sprite_ctrl
// Purpose  : Controller for one question block on the VGA playfield. It tracks
//            the block's hit/bump life cycle and converts the current scan
//            position into a 9-bit address for the question-block sprite
//            ROMs (full or empty image).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk          in   1   pixel-domain clock
//   Reset        in   1   asynchronous, active-high reset
//   frame_start  in   1   one-cycle pulse once per frame (vsync)
//   hit          in   1   one-cycle pulse: Mario's head struck the underside
//   DrawX        in  10   current scan column
//   DrawY        in  10   current scan row
//   read_address out  9   sprite ROM address (registered)
//   in_block     out  1   current pixel is inside the sprite (registered)
//   use_empty    out  1   1 = qblock_empty ROM, 0 = full qblock ROM
//   coin_pulse   out  1   one-cycle pulse when a hit is accepted
//   bump_offset  out  4   current upward displacement in pixels
// ============================================================================
module qblock_sprite_ctrl #(
    parameter logic [9:0] X_POS       = 10'd200,
    parameter logic [9:0] Y_POS       = 10'd160,
    parameter int         SIZE        = 20,
    parameter int         BUMP_HEIGHT = 6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       hit,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [8:0] read_address,
    output logic       in_block,
    output logic       use_empty,
    output logic       coin_pulse,
    output logic [3:0] bump_offset
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_FULL      = 2'd0;
    localparam logic [1:0] c_ST_BUMP_UP   = 2'd1;
    localparam logic [1:0] c_ST_BUMP_DOWN = 2'd2;
    localparam logic [1:0] c_ST_EMPTY     = 2'd3;

    localparam logic [9:0] c_SIZE      = 10'(SIZE);
    localparam logic [9:0] c_SIZE_M1   = 10'(SIZE - 1);
    localparam logic [9:0] c_X_LAST    = 10'(int'(X_POS) + SIZE - 1);
    localparam logic [3:0] c_BUMP_MAX  = 4'(BUMP_HEIGHT);

    // ------------------------------------------------------------------------
    // Life-cycle state machine
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [3:0] r_bump;
    logic       r_coin;

    logic [1:0] w_state_nxt;
    logic [3:0] w_bump_nxt;
    logic       w_coin_nxt;
    logic [3:0] w_bump_inc;
    logic [3:0] w_bump_dec;

    assign w_bump_inc = r_bump + 4'd1;
    assign w_bump_dec = r_bump - 4'd1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= c_ST_FULL;
            r_bump  <= 4'd0;
            r_coin  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bump  <= w_bump_nxt;
            r_coin  <= w_coin_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bump_nxt  = r_bump;
        w_coin_nxt  = 1'b0;
        case (r_state)
            c_ST_FULL: begin
                // A hit wins over a coincident frame_start: the bump starts
                // at zero and that frame is not counted.
                if (hit) begin
                    w_state_nxt = c_ST_BUMP_UP;
                    w_bump_nxt  = 4'd0;
                    w_coin_nxt  = 1'b1;
                end
            end
            c_ST_BUMP_UP: begin
                if (frame_start) begin
                    w_bump_nxt = w_bump_inc;
                    if (w_bump_inc == c_BUMP_MAX) begin
                        w_state_nxt = c_ST_BUMP_DOWN;
                    end
                end
            end
            c_ST_BUMP_DOWN: begin
                // Offset is always >= 1 here, so the decrement cannot wrap.
                if (frame_start) begin
                    w_bump_nxt = w_bump_dec;
                    if (w_bump_dec == 4'd0) begin
                        w_state_nxt = c_ST_EMPTY;
                    end
                end
            end
            default: begin
                // Empty block is terminal; only Reset leaves it.
                w_state_nxt = c_ST_EMPTY;
            end
        endcase
    end

    assign use_empty   = (r_state != c_ST_FULL);
    assign coin_pulse  = r_coin;
    assign bump_offset = r_bump;

    // ------------------------------------------------------------------------
    // Sprite address generation
    // The block is drawn raised by the current bump offset, so its top edge
    // moves up. Y_POS >= BUMP_HEIGHT guarantees no underflow.
    // ------------------------------------------------------------------------
    logic [9:0] w_top;
    logic [9:0] w_bottom;
    logic [9:0] w_dx;
    logic [9:0] w_dy;
    logic       w_in_x;
    logic       w_in_y;
    logic       w_in_block;
    logic [8:0] w_addr;

    logic [8:0] r_read_address;
    logic       r_in_block;

    assign w_top    = Y_POS - {6'd0, r_bump};
    assign w_bottom = w_top + c_SIZE_M1;
    assign w_in_x   = (DrawX >= X_POS) && (DrawX <= c_X_LAST);
    assign w_in_y   = (DrawY >= w_top) && (DrawY <= w_bottom);
    assign w_in_block = w_in_x && w_in_y;

    assign w_dx   = DrawX - X_POS;
    assign w_dy   = DrawY - w_top;
    // Inside the rectangle the linear offset is below SIZE*SIZE <= 512, so
    // keeping only the low 9 bits loses nothing.
    assign w_addr = 9'(w_dy * c_SIZE + w_dx);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_read_address <= 9'd0;
            r_in_block     <= 1'b0;
        end else begin
            r_in_block     <= w_in_block;
            r_read_address <= w_in_block ? w_addr : 9'd0;
        end
    end

    assign read_address = r_read_address;
    assign in_block     = r_in_block;

endmodule
`default_nettype wire

// File: tb/tb_qblock_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_qblock_sprite_ctrl
// Purpose  : Scoreboard bench for qblock_sprite_ctrl. Stimulus tasks update a
//            behavioural model of the block and queue the expected outputs;
//            a negedge monitor pops and compares one entry per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qblock_sprite_ctrl;

    localparam int c_XP = 200;
    localparam int c_YP = 160;
    localparam int c_SZ = 20;
    localparam int c_BH = 6;

    logic       Clk;
    logic       Reset;
    logic       frame_start;
    logic       hit;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [8:0] read_address;
    logic       in_block;
    logic       use_empty;
    logic       coin_pulse;
    logic [3:0] bump_offset;

    qblock_sprite_ctrl #(
        .X_POS      (10'd200),
        .Y_POS      (10'd160),
        .SIZE       (20),
        .BUMP_HEIGHT(6)
    ) u_dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .hit         (hit),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .read_address(read_address),
        .in_block    (in_block),
        .use_empty   (use_empty),
        .coin_pulse  (coin_pulse),
        .bump_offset (bump_offset)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       inb;
        logic [8:0] addr;
        logic       ue;
        logic       coin;
        logic [3:0] bo;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: phase 0=full, 1=rising, 2=falling, 3=empty; offset in pixels.
    int m_phase = 0;
    int m_off   = 0;

    // Sweep bookkeeping
    logic sweep_en = 1'b0;
    int   in_cnt;
    int   seen[512];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what the DUT must show after it.
    task automatic step(input logic fs, input logic h, input int x, input int y);
        exp_t e;
        int   top;
        logic coin;
        frame_start = fs;
        hit         = h;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        @(posedge Clk);
        top   = c_YP - m_off;
        e.inb = (x >= c_XP) && (x <= c_XP + c_SZ - 1) &&
                (y >= top)  && (y <= top + c_SZ - 1);
        e.addr = e.inb ? 9'((y - top) * c_SZ + (x - c_XP)) : 9'd0;
        coin = 1'b0;
        case (m_phase)
            0: if (h) begin m_phase = 1; m_off = 0; coin = 1'b1; end
            1: if (fs) begin m_off++; if (m_off == c_BH) m_phase = 2; end
            2: if (fs) begin m_off--; if (m_off == 0) m_phase = 3; end
            default: ;
        endcase
        e.ue   = (m_phase != 0);
        e.coin = coin;
        e.bo   = 4'(m_off);
        q.push_back(e);
        #1;
    endtask

    // Asynchronous reset away from any clock edge, checked immediately.
    task automatic async_reset(input string tag);
        @(negedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        chk({tag, "_use_empty"},   int'(use_empty),    0);
        chk({tag, "_bump_offset"}, int'(bump_offset),  0);
        chk({tag, "_coin_pulse"},  int'(coin_pulse),   0);
        chk({tag, "_in_block"},    int'(in_block),     0);
        chk({tag, "_read_addr"},   int'(read_address), 0);
        m_phase = 0;
        m_off   = 0;
        frame_start = 1'b0;
        hit         = 1'b0;
        #1;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic sweep(input string tag);
        int nbad;
        @(negedge Clk);
        #1;
        in_cnt = 0;
        for (int i = 0; i < 512; i++) seen[i] = 0;
        sweep_en = 1'b1;
        for (int y = 145; y < 190; y++)
            for (int x = 190; x < 230; x++)
                step(1'b0, 1'b0, x, y);
        @(negedge Clk);
        #1;
        sweep_en = 1'b0;
        chk({tag, "_in_block_count"}, in_cnt, 400);
        nbad = 0;
        for (int i = 0; i < 512; i++)
            if (seen[i] != ((i < 400) ? 1 : 0)) nbad++;
        chk({tag, "_addr_coverage_errors"}, nbad, 0);
    endtask

    // Monitor: one expected entry per clocked cycle, compared mid-cycle.
    always @(negedge Clk) begin
        exp_t e;
        exp_t got;
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {in_block, read_address, use_empty, coin_pulse, bump_offset};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL scoreboard t=%0t: got inb=%0d addr=%0d ue=%0d coin=%0d bo=%0d expected inb=%0d addr=%0d ue=%0d coin=%0d bo=%0d",
                         $time, got.inb, got.addr, got.ue, got.coin, got.bo,
                         e.inb, e.addr, e.ue, e.coin, e.bo);
            end
            if (sweep_en && in_block) begin
                in_cnt++;
                seen[read_address] = seen[read_address] + 1;
            end
        end
    end

    initial begin
        Reset       = 1'b1;
        frame_start = 1'b0;
        hit         = 1'b0;
        DrawX       = 10'd0;
        DrawY       = 10'd0;
        #1;
        chk("reset_use_empty",   int'(use_empty),    0);
        chk("reset_bump_offset", int'(bump_offset),  0);
        chk("reset_coin_pulse",  int'(coin_pulse),   0);
        chk("reset_in_block",    int'(in_block),     0);
        chk("reset_read_addr",   int'(read_address), 0);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // 1: raster at rest, corners and just outside
        step(0, 0, 200, 160);
        step(0, 0, 219, 179);
        step(0, 0, 220, 179);
        step(0, 0, 199, 160);
        step(0, 0, 200, 180);
        step(1, 0, 205, 165);  // frame_start ignored in full state

        // 2 + 3: single hit, re-hits while rising, edge pixels at offset 6
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < c_BH; i++) begin
            step(1, (i == 2), 210, 170);
            step(0, (i == 3), 210, 170);
        end
        step(0, 0, 200, 154);
        step(0, 0, 200, 153);
        step(0, 0, 219, 173);
        step(0, 0, 219, 174);
        for (int i = 0; i < c_BH; i++) begin
            step(1, 0, 200, 154 + i);
            step(0, 1, 200, 160);
        end
        repeat (3) step(1, 1, 201, 161);  // empty: no coin, no bump

        // 4: hit and frame_start together in full state
        async_reset("rst_empty");
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);

        // 5: async reset mid-descent at offset 3, then a fresh hit
        for (int i = 1; i < c_BH; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        chk("pre_reset_offset", m_off, 3);
        async_reset("rst_mid_down");
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // 6: window sweeps at offset 0 and offset 6
        async_reset("rst_sweep");
        sweep("sweep_off0");
        step(0, 1, 0, 0);
        for (int i = 0; i < c_BH; i++) step(1, 0, 0, 0);
        sweep("sweep_off6");

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) async_reset("rst_rand");
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0),
                 int'($urandom_range(192, 226)), int'($urandom_range(148, 186)));
        end

        @(negedge Clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
